// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//
// Shares one memory-controller write port and one read port between
// NUM_CLIENTS requesters. Each cycle at most one write and one read are
// granted, each channel with its own round-robin pointer. Every accepted
// request occupies an entry of an outstanding table keyed by address. The
// controller tags its returns with the address only, so a return is matched
// against the table to find the issuing client, and a new request to an
// address that is still in flight is held off until that entry is freed.
//
// Ports
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   cl_req_*            per-client request (valid, write, address, data);
//                       address/data packed as client k at [k*W +: W]
//   cl_req_ready        combinational grant, one bit per client
//   cl_rd_rsp_valid     one-hot pulse: read data returned to that client
//   cl_wr_rsp_valid     one-hot pulse: write acknowledged to that client
//   rd_rsp_data/address shared read-return fields (hold when idle)
//   wr_rsp_address      shared write-ack address (holds when idle)
//   mc_wr_*, mc_rd_*    registered request issue to the controller
//   mc_*_ret_*          address-tagged returns from the controller
//   occupancy           number of valid table entries
//   err_unmatched       sticky flag: a return matched no table entry
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int TABLE_DEPTH = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CLIENTS-1:0]               cl_req_valid,
  input  logic [NUM_CLIENTS-1:0]               cl_req_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]        cl_req_address,
  input  logic [NUM_CLIENTS*DATA_W-1:0]        cl_req_data,
  output logic [NUM_CLIENTS-1:0]               cl_req_ready,
  output logic [NUM_CLIENTS-1:0]               cl_rd_rsp_valid,
  output logic [NUM_CLIENTS-1:0]               cl_wr_rsp_valid,
  output logic [DATA_W-1:0]                    rd_rsp_data,
  output logic [ADDR_W-1:0]                    rd_rsp_address,
  output logic [ADDR_W-1:0]                    wr_rsp_address,
  output logic [ADDR_W-1:0]                    mc_wr_address,
  output logic [DATA_W-1:0]                    mc_wr_data,
  output logic                                 mc_wr_en,
  output logic [ADDR_W-1:0]                    mc_rd_address,
  output logic                                 mc_rd_en,
  input  logic [ADDR_W-1:0]                    mc_wr_ret_address,
  input  logic                                 mc_wr_ret_ack,
  input  logic [ADDR_W-1:0]                    mc_rd_ret_address,
  input  logic [DATA_W-1:0]                    mc_rd_ret_data,
  input  logic                                 mc_rd_ret_ack,
  output logic [$clog2(TABLE_DEPTH+1)-1:0]     occupancy,
  output logic                                 err_unmatched
);

  localparam int CID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
  localparam int OCC_W = $clog2(TABLE_DEPTH+1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [TABLE_DEPTH-1:0] tbl_valid_q;
  logic [TABLE_DEPTH-1:0] tbl_write_q;
  logic [ADDR_W-1:0]      tbl_addr_q [TABLE_DEPTH];
  logic [CID_W-1:0]       tbl_cid_q  [TABLE_DEPTH];

  logic [CID_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CID_W-1:0]       wr_ptr_d, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;

  logic                   mc_wr_en_q, mc_rd_en_q;
  logic [ADDR_W-1:0]      mc_wr_address_q, mc_rd_address_q;
  logic [DATA_W-1:0]      mc_wr_data_q;

  logic [NUM_CLIENTS-1:0] cl_rd_rsp_valid_q, cl_wr_rsp_valid_q;
  logic [DATA_W-1:0]      rd_rsp_data_q;
  logic [ADDR_W-1:0]      rd_rsp_address_q, wr_rsp_address_q;
  logic                   err_unmatched_q;

  // -------------------------------------------------------------------------
  // Per-client unpacking and candidate qualification
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0]      req_addr [NUM_CLIENTS];
  logic [DATA_W-1:0]      req_data [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] addr_busy;
  logic [NUM_CLIENTS-1:0] wr_cand, rd_cand;

  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      logic busy;

      assign req_addr[gi] = cl_req_address[gi*ADDR_W +: ADDR_W];
      assign req_data[gi] = cl_req_data[gi*DATA_W +: DATA_W];

      // An address is busy while any valid entry holds it, including an
      // entry that is being freed on the coming edge: the request only
      // becomes a candidate in the cycle after the return.
      always_comb begin
        busy = 1'b0;
        for (int t = 0; t < TABLE_DEPTH; t++) begin
          if (tbl_valid_q[t] && (tbl_addr_q[t] == req_addr[gi])) busy = 1'b1;
        end
      end

      assign addr_busy[gi] = busy;
    end
  endgenerate

  assign wr_cand = cl_req_valid &  cl_req_write & ~addr_busy;
  assign rd_cand = cl_req_valid & ~cl_req_write & ~addr_busy;

  // -------------------------------------------------------------------------
  // Round-robin pick: first candidate at or after ptr, wrapping. Scanning
  // offsets from high to low and overwriting leaves the smallest offset.
  // Result is {found, index}.
  // -------------------------------------------------------------------------
  function automatic logic [CID_W:0] rr_pick(input logic [NUM_CLIENTS-1:0] cand,
                                             input logic [CID_W-1:0]       ptr);
    logic [CID_W:0]   res;
    logic [CID_W-1:0] idx;
    res = '0;
    for (int off = NUM_CLIENTS-1; off >= 0; off--) begin
      idx = CID_W'((int'(ptr) + off) % NUM_CLIENTS);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic             wr_found, rd_found;
  logic [CID_W-1:0] wr_win, rd_win;

  assign {wr_found, wr_win} = rr_pick(wr_cand, wr_ptr_q);
  assign {rd_found, rd_win} = rr_pick(rd_cand, rd_ptr_q);

  // -------------------------------------------------------------------------
  // Grant decision. Free space is judged from the count at cycle start; an
  // entry freed by a return on this edge is not reusable until next cycle.
  // A single free slot goes to the read channel.
  // -------------------------------------------------------------------------
  logic free_ge1, free_ge2;
  logic rd_grant, wr_grant;
  logic same_addr;

  assign free_ge1  = (int'(occ_q) + 1) <= TABLE_DEPTH;
  assign free_ge2  = (int'(occ_q) + 2) <= TABLE_DEPTH;
  assign same_addr = rd_found && wr_found && (req_addr[rd_win] == req_addr[wr_win]);

  assign rd_grant = rd_found && free_ge1;
  assign wr_grant = wr_found && free_ge2 && !same_addr;

  always_comb begin
    cl_req_ready = '0;
    if (rd_grant) cl_req_ready[rd_win] = 1'b1;
    if (wr_grant) cl_req_ready[wr_win] = 1'b1;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (rd_grant) rd_ptr_d = (rd_win == CID_W'(NUM_CLIENTS-1)) ? '0 : rd_win + 1'b1;
    if (wr_grant) wr_ptr_d = (wr_win == CID_W'(NUM_CLIENTS-1)) ? '0 : wr_win + 1'b1;
  end

  // -------------------------------------------------------------------------
  // Allocation: lowest free entry, and the second-lowest for the write when
  // a read is granted in the same cycle.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] first_free, second_free;
  logic [IDX_W-1:0] rd_slot, wr_slot;

  always_comb begin
    int n;
    n           = 0;
    first_free  = '0;
    second_free = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (!tbl_valid_q[i]) begin
        if (n == 0)      first_free  = IDX_W'(i);
        else if (n == 1) second_free = IDX_W'(i);
        n = n + 1;
      end
    end
  end

  assign rd_slot = first_free;
  assign wr_slot = rd_grant ? second_free : first_free;

  // -------------------------------------------------------------------------
  // Return matching. The hazard check keeps addresses unique in the table,
  // so at most one entry can hit per channel.
  // -------------------------------------------------------------------------
  logic             rd_hit, wr_hit;
  logic [IDX_W-1:0] rd_hit_idx, wr_hit_idx;
  logic             rd_free, wr_free;

  always_comb begin
    rd_hit     = 1'b0;
    wr_hit     = 1'b0;
    rd_hit_idx = '0;
    wr_hit_idx = '0;
    for (int i = TABLE_DEPTH-1; i >= 0; i--) begin
      if (tbl_valid_q[i] && !tbl_write_q[i] && (tbl_addr_q[i] == mc_rd_ret_address)) begin
        rd_hit     = 1'b1;
        rd_hit_idx = IDX_W'(i);
      end
      if (tbl_valid_q[i] && tbl_write_q[i] && (tbl_addr_q[i] == mc_wr_ret_address)) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IDX_W'(i);
      end
    end
  end

  assign rd_free = mc_rd_ret_ack && rd_hit;
  assign wr_free = mc_wr_ret_ack && wr_hit;

  assign occ_d = occ_q + OCC_W'(rd_grant) + OCC_W'(wr_grant)
                       - OCC_W'(rd_free)  - OCC_W'(wr_free);

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid_q       <= '0;
      tbl_write_q       <= '0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        tbl_addr_q[i] <= '0;
        tbl_cid_q[i]  <= '0;
      end
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      occ_q             <= '0;
      mc_wr_en_q        <= 1'b0;
      mc_rd_en_q        <= 1'b0;
      mc_wr_address_q   <= '0;
      mc_wr_data_q      <= '0;
      mc_rd_address_q   <= '0;
      cl_rd_rsp_valid_q <= '0;
      cl_wr_rsp_valid_q <= '0;
      rd_rsp_data_q     <= '0;
      rd_rsp_address_q  <= '0;
      wr_rsp_address_q  <= '0;
      err_unmatched_q   <= 1'b0;
    end else begin
      // Frees and allocations never touch the same entry: a hit is on a
      // valid entry, an allocation on an invalid one.
      if (rd_free) tbl_valid_q[rd_hit_idx] <= 1'b0;
      if (wr_free) tbl_valid_q[wr_hit_idx] <= 1'b0;

      if (rd_grant) begin
        tbl_valid_q[rd_slot] <= 1'b1;
        tbl_write_q[rd_slot] <= 1'b0;
        tbl_addr_q[rd_slot]  <= req_addr[rd_win];
        tbl_cid_q[rd_slot]   <= rd_win;
      end
      if (wr_grant) begin
        tbl_valid_q[wr_slot] <= 1'b1;
        tbl_write_q[wr_slot] <= 1'b1;
        tbl_addr_q[wr_slot]  <= req_addr[wr_win];
        tbl_cid_q[wr_slot]   <= wr_win;
      end

      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;

      // Issue: enables pulse for one cycle; address/data hold otherwise.
      mc_rd_en_q <= rd_grant;
      mc_wr_en_q <= wr_grant;
      if (rd_grant) mc_rd_address_q <= req_addr[rd_win];
      if (wr_grant) begin
        mc_wr_address_q <= req_addr[wr_win];
        mc_wr_data_q    <= req_data[wr_win];
      end

      // Responses: one-hot pulse to the owner; shared fields hold when idle.
      cl_rd_rsp_valid_q <= '0;
      cl_wr_rsp_valid_q <= '0;
      if (rd_free) begin
        cl_rd_rsp_valid_q[tbl_cid_q[rd_hit_idx]] <= 1'b1;
        rd_rsp_data_q    <= mc_rd_ret_data;
        rd_rsp_address_q <= mc_rd_ret_address;
      end
      if (wr_free) begin
        cl_wr_rsp_valid_q[tbl_cid_q[wr_hit_idx]] <= 1'b1;
        wr_rsp_address_q <= mc_wr_ret_address;
      end

      if ((mc_rd_ret_ack && !rd_hit) || (mc_wr_ret_ack && !wr_hit)) begin
        err_unmatched_q <= 1'b1;
      end
    end
  end

  assign mc_wr_en        = mc_wr_en_q;
  assign mc_wr_address   = mc_wr_address_q;
  assign mc_wr_data      = mc_wr_data_q;
  assign mc_rd_en        = mc_rd_en_q;
  assign mc_rd_address   = mc_rd_address_q;
  assign cl_rd_rsp_valid = cl_rd_rsp_valid_q;
  assign cl_wr_rsp_valid = cl_wr_rsp_valid_q;
  assign rd_rsp_data     = rd_rsp_data_q;
  assign rd_rsp_address  = rd_rsp_address_q;
  assign wr_rsp_address  = wr_rsp_address_q;
  assign occupancy       = occ_q;
  assign err_unmatched   = err_unmatched_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter
//
// Directed bench for mem_req_arbiter with hand-computed expectations.
// Inputs change 1 ns after a rising edge; registered outputs are sampled at
// the same point, combinational ready 1 ns later.
// ---------------------------------------------------------------------------
module tb_mem_req_arbiter;

  localparam int N  = 4;
  localparam int TD = 8;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      cl_req_valid, cl_req_write;
  logic [N*AW-1:0]   cl_req_address;
  logic [N*DW-1:0]   cl_req_data;
  logic [N-1:0]      cl_req_ready, cl_rd_rsp_valid, cl_wr_rsp_valid;
  logic [DW-1:0]     rd_rsp_data;
  logic [AW-1:0]     rd_rsp_address, wr_rsp_address;
  logic [AW-1:0]     mc_wr_address, mc_rd_address;
  logic [DW-1:0]     mc_wr_data;
  logic              mc_wr_en, mc_rd_en;
  logic [AW-1:0]     mc_wr_ret_address, mc_rd_ret_address;
  logic              mc_wr_ret_ack, mc_rd_ret_ack;
  logic [DW-1:0]     mc_rd_ret_data;
  logic [3:0]        occupancy;
  logic              err_unmatched;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NUM_CLIENTS(N), .TABLE_DEPTH(TD), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cl_req_valid      (cl_req_valid),
    .cl_req_write      (cl_req_write),
    .cl_req_address    (cl_req_address),
    .cl_req_data       (cl_req_data),
    .cl_req_ready      (cl_req_ready),
    .cl_rd_rsp_valid   (cl_rd_rsp_valid),
    .cl_wr_rsp_valid   (cl_wr_rsp_valid),
    .rd_rsp_data       (rd_rsp_data),
    .rd_rsp_address    (rd_rsp_address),
    .wr_rsp_address    (wr_rsp_address),
    .mc_wr_address     (mc_wr_address),
    .mc_wr_data        (mc_wr_data),
    .mc_wr_en          (mc_wr_en),
    .mc_rd_address     (mc_rd_address),
    .mc_rd_en          (mc_rd_en),
    .mc_wr_ret_address (mc_wr_ret_address),
    .mc_wr_ret_ack     (mc_wr_ret_ack),
    .mc_rd_ret_address (mc_rd_ret_address),
    .mc_rd_ret_data    (mc_rd_ret_data),
    .mc_rd_ret_ack     (mc_rd_ret_ack),
    .occupancy         (occupancy),
    .err_unmatched     (err_unmatched)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    cl_req_valid   = '0;
    cl_req_write   = '0;
    cl_req_address = '0;
    cl_req_data    = '0;
  endtask

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cl_req_valid[k]             = 1'b1;
    cl_req_write[k]             = wr;
    cl_req_address[k*AW +: AW]  = a;
    cl_req_data[k*DW +: DW]     = d;
  endtask

  function automatic logic [AW-1:0] rr_addr(input int i, input int k);
    return AW'(32'h1000 + i*16 + k);
  endfunction

  function automatic logic [AW-1:0] full_addr(input int j, input int k);
    return AW'(32'h2000 + j*16 + k);
  endfunction

  int          g [5] = '{0, 1, 2, 3, 0};
  logic [N-1:0] oh;

  initial begin
    rst_n             = 1'b0;
    clear_req();
    mc_wr_ret_address = '0;
    mc_wr_ret_ack     = 1'b0;
    mc_rd_ret_address = '0;
    mc_rd_ret_data    = '0;
    mc_rd_ret_ack     = 1'b0;

    // ---------------- reset state ----------------
    step();
    check_eq("rst_occupancy", occupancy, 0);
    check_eq("rst_mc_wr_en", mc_wr_en, 0);
    check_eq("rst_mc_rd_en", mc_rd_en, 0);
    check_eq("rst_err", err_unmatched, 0);
    check_eq("rst_rd_rsp_valid", cl_rd_rsp_valid, 0);
    step();
    rst_n = 1'b1;

    // ---------------- single write ----------------
    set_req(2, 1'b1, 16'h0010, 16'hBEEF);
    #1 check_eq("t1_ready", cl_req_ready, 4'b0100);
    step();
    clear_req();
    check_eq("t1_mc_wr_en", mc_wr_en, 1);
    check_eq("t1_mc_wr_address", mc_wr_address, 16'h0010);
    check_eq("t1_mc_wr_data", mc_wr_data, 16'hBEEF);
    check_eq("t1_mc_rd_en", mc_rd_en, 0);
    check_eq("t1_occ_1", occupancy, 1);
    step();
    check_eq("t1_mc_wr_en_one_cycle", mc_wr_en, 0);
    mc_wr_ret_address = 16'h0010;
    mc_wr_ret_ack     = 1'b1;
    step();
    mc_wr_ret_ack = 1'b0;
    check_eq("t1_wr_rsp_valid", cl_wr_rsp_valid, 4'b0100);
    check_eq("t1_wr_rsp_address", wr_rsp_address, 16'h0010);
    check_eq("t1_occ_0", occupancy, 0);
    step();
    check_eq("t1_wr_rsp_valid_drop", cl_wr_rsp_valid, 0);
    check_eq("t1_wr_rsp_address_hold", wr_rsp_address, 16'h0010);

    // ---------------- round-robin reads, immediate returns ----------------
    for (int i = 0; i <= 6; i++) begin
      if (i >= 1 && i <= 5) begin
        check_eq($sformatf("t2_mc_rd_en_%0d", i), mc_rd_en, 1);
        check_eq($sformatf("t2_mc_rd_address_%0d", i), mc_rd_address, rr_addr(i-1, g[i-1]));
      end
      if (i >= 2) begin
        oh = 4'b0001 << g[i-2];
        check_eq($sformatf("t2_rd_rsp_valid_%0d", i), cl_rd_rsp_valid, oh);
        check_eq($sformatf("t2_rd_rsp_address_%0d", i), rd_rsp_address, rr_addr(i-2, g[i-2]));
      end
      clear_req();
      if (i <= 4) begin
        for (int k = 0; k < N; k++) set_req(k, 1'b0, rr_addr(i, k), '0);
      end
      if (i >= 1 && i <= 5) begin
        mc_rd_ret_ack     = 1'b1;
        mc_rd_ret_address = rr_addr(i-1, g[i-1]);
        mc_rd_ret_data    = DW'(16'h0A00 + i);
      end else begin
        mc_rd_ret_ack = 1'b0;
      end
      #1;
      if (i <= 4) begin
        oh = 4'b0001 << g[i];
        check_eq($sformatf("t2_grant_%0d", i), cl_req_ready, oh);
      end
      step();
    end
    mc_rd_ret_ack = 1'b0;
    clear_req();
    check_eq("t2_occ_empty", occupancy, 0);

    // ---------------- address hazard ----------------
    set_req(0, 1'b0, 16'h0040, '0);
    #1 check_eq("t3_rd_grant", cl_req_ready, 4'b0001);
    step();
    clear_req();
    set_req(1, 1'b1, 16'h0040, 16'h1234);
    #1 check_eq("t3_wr_blocked_0", cl_req_ready, 0);
    step();
    check_eq("t3_wr_blocked_1", cl_req_ready, 0);
    mc_rd_ret_address = 16'h0040;
    mc_rd_ret_data    = 16'h5555;
    mc_rd_ret_ack     = 1'b1;
    #1 check_eq("t3_wr_blocked_ret_cycle", cl_req_ready, 0);
    step();
    mc_rd_ret_ack = 1'b0;
    check_eq("t3_rd_rsp_valid", cl_rd_rsp_valid, 4'b0001);
    check_eq("t3_rd_rsp_data", rd_rsp_data, 16'h5555);
    #1 check_eq("t3_wr_granted_after", cl_req_ready, 4'b0010);
    step();
    clear_req();
    check_eq("t3_mc_wr_en", mc_wr_en, 1);
    check_eq("t3_mc_wr_address", mc_wr_address, 16'h0040);
    check_eq("t3_mc_wr_data", mc_wr_data, 16'h1234);
    mc_wr_ret_address = 16'h0040;
    mc_wr_ret_ack     = 1'b1;
    step();
    mc_wr_ret_ack = 1'b0;
    check_eq("t3_wr_rsp_valid", cl_wr_rsp_valid, 4'b0010);
    check_eq("t3_occ_0", occupancy, 0);

    // same-cycle read and write to one address
    set_req(2, 1'b1, 16'h0050, 16'hAAAA);
    set_req(3, 1'b0, 16'h0050, '0);
    #1 check_eq("t3s_read_wins", cl_req_ready, 4'b1000);
    step();
    clear_req();
    set_req(2, 1'b1, 16'h0050, 16'hAAAA);
    check_eq("t3s_mc_rd_en", mc_rd_en, 1);
    check_eq("t3s_mc_wr_en_0", mc_wr_en, 0);
    mc_rd_ret_address = 16'h0050;
    mc_rd_ret_ack     = 1'b1;
    #1 check_eq("t3s_wr_held", cl_req_ready, 0);
    step();
    mc_rd_ret_ack = 1'b0;
    check_eq("t3s_rd_rsp_valid", cl_rd_rsp_valid, 4'b1000);
    #1 check_eq("t3s_wr_follows", cl_req_ready, 4'b0100);
    step();
    clear_req();
    check_eq("t3s_mc_wr_data", mc_wr_data, 16'hAAAA);
    mc_wr_ret_address = 16'h0050;
    mc_wr_ret_ack     = 1'b1;
    step();
    mc_wr_ret_ack = 1'b0;
    check_eq("t3s_wr_rsp_valid", cl_wr_rsp_valid, 4'b0100);
    check_eq("t3s_occ_0", occupancy, 0);

    // ---------------- table full ----------------
    for (int j = 0; j < 8; j++) begin
      clear_req();
      for (int k = 0; k < N; k++) set_req(k, 1'b0, full_addr(j, k), '0);
      oh = 4'b0001 << (j % 4);
      #1 check_eq($sformatf("t4_fill_grant_%0d", j), cl_req_ready, oh);
      step();
    end
    check_eq("t4_occ_full", occupancy, 8);
    clear_req();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, full_addr(8, k), '0);
    #1 check_eq("t4_full_no_grant", cl_req_ready, 0);
    step();
    mc_rd_ret_address = full_addr(0, 0);
    mc_rd_ret_ack     = 1'b1;
    #1 check_eq("t4_full_ret_cycle", cl_req_ready, 0);
    step();
    mc_rd_ret_ack = 1'b0;
    check_eq("t4_occ_7", occupancy, 7);
    #1 check_eq("t4_one_grant", cl_req_ready, 4'b0001);
    step();
    check_eq("t4_occ_refull", occupancy, 8);
    clear_req();
    set_req(0, 1'b1, 16'h3000, 16'h9999);
    set_req(1, 1'b0, 16'h3100, '0);
    mc_rd_ret_address = full_addr(1, 1);
    mc_rd_ret_ack     = 1'b1;
    #1 check_eq("t4_full_both_req", cl_req_ready, 0);
    step();
    mc_rd_ret_ack = 1'b0;
    #1 check_eq("t4_one_free_read_only", cl_req_ready, 4'b0010);
    step();
    clear_req();
    check_eq("t4_mc_rd_en", mc_rd_en, 1);
    check_eq("t4_mc_wr_en_stalled", mc_wr_en, 0);
    check_eq("t4_occ_8", occupancy, 8);

    // ---------------- unmatched return and reset ----------------
    mc_rd_ret_address = 16'h7777;
    mc_rd_ret_ack     = 1'b1;
    step();
    mc_rd_ret_ack = 1'b0;
    check_eq("t6_err_set", err_unmatched, 1);
    check_eq("t6_no_rsp", cl_rd_rsp_valid, 0);
    step();
    check_eq("t6_err_sticky", err_unmatched, 1);
    mc_rd_ret_address = full_addr(2, 2);
    mc_rd_ret_data    = 16'h0777;
    mc_rd_ret_ack     = 1'b1;
    step();
    mc_rd_ret_ack = 1'b0;
    check_eq("t6_rsp_before_reset", cl_rd_rsp_valid, 4'b0100);
    check_eq("t6_occ_before_reset", occupancy, 7);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_async_rsp_clr", cl_rd_rsp_valid, 0);
    check_eq("t6_async_occ_clr", occupancy, 0);
    check_eq("t6_async_err_clr", err_unmatched, 0);
    check_eq("t6_async_rd_rsp_data_clr", rd_rsp_data, 0);
    check_eq("t6_async_mc_rd_address_clr", mc_rd_address, 0);
    step();
    rst_n = 1'b1;
    mc_rd_ret_address = full_addr(3, 3);
    mc_rd_ret_ack     = 1'b1;
    step();
    mc_rd_ret_ack = 1'b0;
    check_eq("t6_post_reset_unmatched", err_unmatched, 1);
    check_eq("t6_post_reset_no_rsp", cl_rd_rsp_valid, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("t6_err_cleared", err_unmatched, 0);

    // ---------------- simultaneous returns ----------------
    set_req(3, 1'b0, 16'h0100, '0);
    set_req(1, 1'b1, 16'h0200, 16'h2222);
    #1 check_eq("t5_both_grant", cl_req_ready, 4'b1010);
    step();
    clear_req();
    check_eq("t5_occ_2", occupancy, 2);
    check_eq("t5_mc_rd_address", mc_rd_address, 16'h0100);
    check_eq("t5_mc_wr_address", mc_wr_address, 16'h0200);
    mc_rd_ret_address = 16'h0100;
    mc_rd_ret_data    = 16'hCAFE;
    mc_rd_ret_ack     = 1'b1;
    mc_wr_ret_address = 16'h0200;
    mc_wr_ret_ack     = 1'b1;
    step();
    mc_rd_ret_ack = 1'b0;
    mc_wr_ret_ack = 1'b0;
    check_eq("t5_rd_rsp_valid", cl_rd_rsp_valid, 4'b1000);
    check_eq("t5_wr_rsp_valid", cl_wr_rsp_valid, 4'b0010);
    check_eq("t5_rd_rsp_data", rd_rsp_data, 16'hCAFE);
    check_eq("t5_wr_rsp_address", wr_rsp_address, 16'h0200);
    check_eq("t5_occ_0", occupancy, 0);
    check_eq("t5_err_clear", err_unmatched, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares one `memory_controller` request/return port pair between `NUM_CLIENTS` requesters. Per-channel round-robin arbitration selects at most one write and one read per cycle. Each accepted request is recorded in an outstanding table keyed by address. Address-tagged returns from the controller are routed back to the client that issued them, and a new request to an address already in flight is held off, because the controller's tag is the address.

## Interface
- `NUM_CLIENTS`, 4: number of requesters (2..8).
- `TABLE_DEPTH`, 8: outstanding-table entries, shared by reads and writes.
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.

- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cl_req_valid`  in  NUM_CLIENTS  per-client request valid.
- `cl_req_write`  in  NUM_CLIENTS  1 = write, 0 = read.
- `cl_req_address`  in  NUM_CLIENTS*ADDR_W  client k at bits [k*ADDR_W +: ADDR_W].
- `cl_req_data`  in  NUM_CLIENTS*DATA_W  write data, same packing.
- `cl_req_ready`  out  NUM_CLIENTS  combinational grant; a request is accepted when valid & ready.
- `cl_rd_rsp_valid`  out  NUM_CLIENTS  one-hot, read data returned to this client.
- `cl_wr_rsp_valid`  out  NUM_CLIENTS  one-hot, write acknowledged to this client.
- `rd_rsp_data`  out  DATA_W  shared read-return data.
- `rd_rsp_address`  out  ADDR_W  shared read-return address.
- `wr_rsp_address`  out  ADDR_W  shared write-ack address.
- `mc_wr_address`, `mc_wr_data`, `mc_wr_en`  out  ADDR_W/DATA_W/1  to controller write port.
- `mc_rd_address`, `mc_rd_en`  out  ADDR_W/1  to controller read port.
- `mc_wr_ret_address`, `mc_wr_ret_ack`  in  ADDR_W/1  from controller.
- `mc_rd_ret_address`, `mc_rd_ret_data`, `mc_rd_ret_ack`  in  ADDR_W/DATA_W/1  from controller.
- `occupancy`  out  clog2(TABLE_DEPTH+1)  valid table entries.
- `err_unmatched`  out  1  sticky; a return matched no entry.

## Operation
**Table entry:** {valid, is_write, address, client_id}.

**Candidate:** client k is a write (read) candidate when `cl_req_valid[k]` & `cl_req_write[k]` = 1 (0), and its address matches no valid table entry.

**Round-robin:** separate pointers `wr_ptr` and `rd_ptr`.
- The candidate at or after the pointer, in increasing index order with wrap, wins.
- On a grant to client k, the pointer becomes (k+1) mod NUM_CLIENTS. With no grant, the pointer holds.

**Free entries:** counted at cycle start. Entries freed by returns in the same cycle do not count until the next cycle.
- 0 free: no grants.
- 1 free: read grant only; the write stalls.
- ≥2 free: both channels may grant.

**Same-cycle address conflict:** if the read and write winners carry the same address, the read is granted. The write is not granted and `wr_ptr` holds.

**Allocation:** an accepted request allocates the lowest-index free entry; a read takes the lower index when both are accepted. `cl_req_ready[k]` is high only for granted clients.

**Returns:**
- A return ack searches the table for a valid entry with the same address and type. On a hit, the entry is freed and the owning client's response bit is pulsed.
- Read and write returns may occur in the same cycle, to the same or different clients; both are handled.
- On a miss, the return is dropped and `err_unmatched` is set until reset.

**Issue:** accepted requests drive the `mc_*` outputs, registered.

## Timing
**Reset:** all outputs 0, `occupancy` 0, table invalid, `wr_ptr` = `rd_ptr` = 0. Reset mid-operation discards every in-flight entry; returns arriving after reset are unmatched.

**Request path:** accept at edge t → `mc_wr_en`/`mc_rd_en` high with address/data for exactly one cycle after edge t. `mc_*_en` is low in cycles with no accept.

**Return path:**
- `mc_*_ret_ack` sampled high at edge t.
- `cl_*_rsp_valid` plus the `rsp_*` fields are valid for one cycle after edge t.
- The entry is freed at edge t and is usable for allocation at edge t+1.
- `rsp_*` fields hold their last value when not valid.

**Occupancy:** `occupancy` updates at each edge with +allocations −frees (net −2..+2). It never exceeds TABLE_DEPTH.

**Same-address ordering:** a request to an address whose entry is freed at edge t becomes a candidate in the cycle after edge t. A freed address is never re-issued in the same cycle it returns.

## Test plan
- **Single write.** Client 2 writes addr 0x0010, data 0xBEEF.
  - `cl_req_ready[2]` high in the same cycle.
  - `mc_wr_en` high for one cycle with 0x0010/0xBEEF.
  - Controller ack for 0x0010 → `cl_wr_rsp_valid` = 4'b0100, `wr_rsp_address` = 0x0010.
  - `occupancy` goes 1 → 0.
- **Round-robin.** All 4 clients hold reads to distinct addresses, with returns immediate.
  - Grants go 0, 1, 2, 3, 0 on successive cycles.
  - The read returns for each address pulse the matching one-hot response bit.
- **Address hazard.** Client 0 reads 0x0040 and is outstanding; client 1 writes 0x0040.
  - `cl_req_ready[1]` stays low until the cycle after the read-return edge, then is granted.
  - Same-cycle read/write to one address: the read is granted, the write follows the next cycle.
- **Table full.** Issue 8 reads with no returns.
  - `occupancy` = 8 and all `cl_req_ready` are low.
  - One return → exactly one grant in the cycle after that edge.
  - With one free entry and both channels requesting, only the read is granted.
- **Simultaneous returns.** Read ack 0x0100 (client 3) and write ack 0x0200 (client 1) arrive on one edge.
  - Both `cl_rd_rsp_valid[3]` and `cl_wr_rsp_valid[1]` are high.
  - `occupancy` drops by 2.
- **Unmatched return and reset.**
  - Read ack for address 0x7777 with no entry → `err_unmatched` = 1 and stays set.
  - `rst_n` low mid-flight clears all outputs and the table asynchronously, and `err_unmatched` returns to 0.
